mux_scan_serializer: RTL and testbench

MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

---
 rtl/mux_scan_serializer.sv | 104 ++++++++++
 tb/tb_mux_scan_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_serializer.sv
// Byte-to-bit serializer that drives an external 8:1 mux (word_q/sel) and forwards
// its returned bit as a valid/ready/last serial stream, with optional even-parity beat.
module mux_scan_serializer #(
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [7:0] word_q,
  output logic [2:0] sel,
  input  logic       mux_out,
  output logic       ser_data,
  output logic       ser_valid,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_e;

  localparam logic [2:0] SEL_START = (LSB_FIRST != 0) ? 3'd0 : 3'd7;

  state_e     state_q, state_d;
  logic [7:0] word_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       beat, last_beat, load;

  assign sel       = sel_q;
  assign frame_cnt = frame_cnt_q;

  // Outputs decode state only, so ser_valid never depends on ser_ready.
  always_comb begin
    ser_valid = (state_q != IDLE);
    busy      = (state_q != IDLE);
    ser_last  = (state_q == PAR) ||
                ((state_q == DATA) && (cnt_q == 3'd7) && (PARITY_EN == 0));
    case (state_q)
      DATA:    ser_data = mux_out;
      PAR:     ser_data = ^word_q;
      default: ser_data = 1'b0;
    endcase
    beat       = ser_valid && ser_ready;
    last_beat  = beat && ser_last;
    load_ready = (state_q == IDLE) || (ser_last && ser_ready);
    load       = load_valid && load_ready;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      DATA: begin
        if (beat) begin
          if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
            sel_d = (LSB_FIRST != 0) ? sel_q + 3'd1 : sel_q - 3'd1;
          end else if (PARITY_EN != 0) begin
            state_d = PAR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PAR: begin
        if (beat) state_d = IDLE;
      end
      default: ;
    endcase
    if (last_beat) frame_cnt_d = frame_cnt_q + 8'd1;
    // A load on the final beat overrides the return to IDLE for back-to-back frames.
    if (load) begin
      word_d  = load_data;
      sel_d   = SEL_START;
      cnt_d   = '0;
      state_d = DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: lane 0 is LSB-first without parity, lane 1 is
// MSB-first with parity; a queue-of-beats model checks every cycle of both lanes.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] lv, sr, s_valid, s_data, s_last, l_rdy, bsy, mux;
  logic [7:0] ld [2];
  logic [7:0] wq [2];
  logic [7:0] fc [2];
  logic [2:0] sl [2];
  int         n_tests, n_fail;
  logic [7:0] efc [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       d;
    logic       last;
    logic [2:0] sel;
  } beat_t;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit LSB = (g == 0);
    localparam bit PAR = (g == 1);

    mux_scan_serializer #(.LSB_FIRST(LSB ? 1 : 0), .PARITY_EN(PAR ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(lv[g]), .load_data(ld[g]),
      .load_ready(l_rdy[g]), .word_q(wq[g]), .sel(sl[g]), .mux_out(mux[g]),
      .ser_data(s_data[g]), .ser_valid(s_valid[g]), .ser_last(s_last[g]),
      .ser_ready(sr[g]), .busy(bsy[g]), .frame_cnt(fc[g])
    );

    // External 8:1 mux.
    assign mux[g] = wq[g][sl[g]];

    beat_t      q[$];
    beat_t      b;
    logic [2:0] last_sel = '0;
    logic [7:0] m_word = '0;
    logic [7:0] m_cnt = '0;
    bit         rdy;
    int         bi;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        last_sel = '0;
        m_word   = '0;
        m_cnt    = '0;
      end else begin
        rdy = (q.size() == 0) || (q[0].last && sr[g]);
        if (q.size() != 0 && sr[g]) begin
          last_sel = q[0].sel;
          if (q[0].last) m_cnt++;
          void'(q.pop_front());
        end
        if (lv[g] && rdy) begin
          m_word = ld[g];
          for (int k = 0; k < 8; k++) begin
            bi     = LSB ? k : 7 - k;
            b.d    = ld[g][bi];
            b.last = (k == 7) && !PAR;
            b.sel  = 3'(bi);
            q.push_back(b);
          end
          if (PAR) begin
            b.d    = ^ld[g];
            b.last = 1'b1;
            b.sel  = 3'd0;
            q.push_back(b);
          end
        end
      end
    end

    always @(negedge clk) begin
      if (q.size() != 0) begin
        chk($sformatf("L%0d ser_valid", g), s_valid[g], 1);
        chk($sformatf("L%0d ser_data", g), s_data[g], q[0].d);
        chk($sformatf("L%0d ser_last", g), s_last[g], q[0].last);
        chk($sformatf("L%0d sel", g), sl[g], q[0].sel);
        chk($sformatf("L%0d load_ready", g), l_rdy[g], q[0].last && sr[g]);
      end else begin
        chk($sformatf("L%0d ser_valid", g), s_valid[g], 0);
        chk($sformatf("L%0d ser_data", g), s_data[g], 0);
        chk($sformatf("L%0d ser_last", g), s_last[g], 0);
        chk($sformatf("L%0d sel", g), sl[g], last_sel);
        chk($sformatf("L%0d load_ready", g), l_rdy[g], 1);
      end
      chk($sformatf("L%0d busy", g), bsy[g], q.size() != 0);
      chk($sformatf("L%0d word_q", g), wq[g], m_word);
      chk($sformatf("L%0d frame_cnt", g), fc[g], m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [8:0] stream;
    int         stall_at;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int         n;
    logic [2:0] es;
    n = (v.d == 1) ? 9 : 8;
    lv[v.d] = 1'b1;
    ld[v.d] = v.data;
    sr[v.d] = 1'b1;
    chk("idle load_ready", l_rdy[v.d], 1);
    cyc();
    lv[v.d] = 1'b0;
    ld[v.d] = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k < 8) es = (v.d == 1) ? 3'(7 - k) : 3'(k);
      else       es = 3'd0;
      chk($sformatf("frame %0h beat%0d valid", v.data, k), s_valid[v.d], 1);
      chk($sformatf("frame %0h beat%0d data", v.data, k), s_data[v.d], v.stream[k]);
      chk($sformatf("frame %0h beat%0d last", v.data, k), s_last[v.d], k == n - 1);
      chk($sformatf("frame %0h beat%0d sel", v.data, k), sl[v.d], es);
      if (k == v.stall_at) begin
        sr[v.d] = 1'b0;
        repeat (3) begin
          cyc();
          chk("stall valid", s_valid[v.d], 1);
          chk("stall sel", sl[v.d], es);
          chk("stall data", s_data[v.d], v.stream[k]);
          chk("stall word_q", wq[v.d], v.data);
        end
        sr[v.d] = 1'b1;
      end
      cyc();
    end
    efc[v.d]++;
    chk("frame end valid", s_valid[v.d], 0);
    chk("frame end frame_cnt", fc[v.d], efc[v.d]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    efc[0] = '0;
    efc[1] = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 8'hA5, 9'h0A5, -1};
    vecs[1] = '{0, 8'h01, 9'h001, -1};
    vecs[2] = '{0, 8'h3C, 9'h03C, 3};
    vecs[3] = '{1, 8'h81, 9'h081, -1};
    vecs[4] = '{1, 8'h01, 9'h180, -1};
    vecs[5] = '{1, 8'hD2, 9'h04B, 2};
    n_tests = 0;
    n_fail  = 0;
    efc[0]  = '0;
    efc[1]  = '0;
    lv      = '0;
    sr      = '0;
    ld[0]   = '0;
    ld[1]   = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst ser_valid", s_valid[g], 0);
      chk("rst ser_last", s_last[g], 0);
      chk("rst ser_data", s_data[g], 0);
      chk("rst busy", bsy[g], 0);
      chk("rst sel", sl[g], 0);
      chk("rst word_q", wq[g], 0);
      chk("rst frame_cnt", fc[g], 0);
      chk("rst load_ready", l_rdy[g], 1);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    sr    = 2'b11;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back FF then 00 on lane 0 with load_valid held high.
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    cyc();
    ld[0] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b2b beat%0d valid", k), s_valid[0], 1);
      chk($sformatf("b2b beat%0d data", k), s_data[0], k < 8);
      chk($sformatf("b2b beat%0d last", k), s_last[0], k == 7 || k == 15);
      chk($sformatf("b2b beat%0d load_ready", k), l_rdy[0], k == 7 || k == 15);
      cyc();
      if (k == 7) lv[0] = 1'b0;
    end
    efc[0] += 8'd2;
    chk("b2b end valid", s_valid[0], 0);
    chk("b2b frame_cnt", fc[0], efc[0]);

    // Reset during beat 5 of lane 0.
    lv[0] = 1'b1;
    ld[0] = 8'hA5;
    cyc();
    lv[0] = 1'b0;
    repeat (4) cyc();
    chk("pre-rst sel", sl[0], 3'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst ser_valid", s_valid[0], 0);
    chk("midrst sel", sl[0], 0);
    chk("midrst frame_cnt", fc[0], 0);
    chk("midrst ser_data", s_data[0], 0);
    chk("midrst load_ready", l_rdy[0], 1);
    efc[0] = '0;
    efc[1] = '0;
    repeat (2) cyc();
    chk("held rst ser_valid", s_valid[0], 0);
    rst_n = 1'b1;
    run_frame(vecs[1]);

    // 256 frames on lane 0 wrap the frame counter.
    do_reset();
    lv[0] = 1'b1;
    ld[0] = 8'hC3;
    cyc();
    repeat (255 * 8) cyc();
    chk("wrap 255", fc[0], 8'd255);
    repeat (8) cyc();
    chk("wrap 0", fc[0], 8'd0);
    lv[0] = 1'b0;
    repeat (10) cyc();

    // Random traffic on both lanes, checked by the per-cycle model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lv[0] = 1'($urandom);
      lv[1] = 1'($urandom);
      ld[0] = 8'($urandom);
      ld[1] = 8'($urandom);
      sr[0] = ($urandom_range(3) != 0);
      sr[1] = ($urandom_range(3) != 0);
      cyc();
    end
    lv = '0;
    sr = 2'b11;
    repeat (12) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
